// File: rtl/pcileech_board_ctl_if.sv
`default_nettype none
// ============================================================================
// Module      : pcileech_board_ctl_if
// Description : Signal bundle between the board pads / PCILeech logic and the
//               board user-I/O controller.
//               slave  - the controller (consumes pads and LED controls).
//               master - the surrounding board logic.
//   btn_in      raw button pads (asynchronous)
//   btn_level   debounced pressed state, 1 = pressed
//   btn_press   1-cycle debounced press event
//   btn_release 1-cycle debounced release event
//   btn_long    1-cycle long-press event
//   rst_req     stretched reset request
//   led_mode    2 bits per LED: 00 off, 01 on, 10 activity, 11 blink
//   led_act     activity strobes (synchronous to clk)
//   led_invert  per-LED output inversion
//   led_out     LED drive
// Revision    : 1.0 - initial release
// ============================================================================
interface pcileech_board_ctl_if #(
    parameter int NUM_BTN = 2,
    parameter int NUM_LED = 2
);
    logic [NUM_BTN-1:0]   btn_in;
    logic [NUM_BTN-1:0]   btn_level;
    logic [NUM_BTN-1:0]   btn_press;
    logic [NUM_BTN-1:0]   btn_release;
    logic [NUM_BTN-1:0]   btn_long;
    logic                 rst_req;
    logic [2*NUM_LED-1:0] led_mode;
    logic [NUM_LED-1:0]   led_act;
    logic [NUM_LED-1:0]   led_invert;
    logic [NUM_LED-1:0]   led_out;

    modport slave (
        input  btn_in, led_mode, led_act, led_invert,
        output btn_level, btn_press, btn_release, btn_long, rst_req, led_out
    );

    modport master (
        output btn_in, led_mode, led_act, led_invert,
        input  btn_level, btn_press, btn_release, btn_long, rst_req, led_out
    );
endinterface
`default_nettype wire

// File: rtl/pcileech_board_ctl.sv
`default_nettype none
// ============================================================================
// Module      : pcileech_board_ctl
// Description : Board-level user-I/O controller. Synchronises and debounces
//               NUM_BTN buttons (press/release/long-press events), raises a
//               stretched reset request on a long press of RST_BTN_IDX, and
//               drives NUM_LED LEDs in off/on/activity/blink modes with
//               per-LED inversion.
// Ports       : clk - system clock
//               rst - asynchronous active-high reset
//               bus - pcileech_board_ctl_if.slave (pads, events, LED controls)
// Revision    : 1.0 - initial release
// ============================================================================
module pcileech_board_ctl #(
    parameter int NUM_BTN            = 2,
    parameter int NUM_LED            = 2,
    parameter int BTN_ACTIVE_LOW     = 1,
    parameter int DEBOUNCE_CYCLES    = 1000000,
    parameter int LONGPRESS_CYCLES   = 200000000,
    parameter int RST_BTN_IDX        = 1,
    parameter int RST_PULSE_CYCLES   = 16,
    parameter int ACT_STRETCH_CYCLES = 5000000,
    parameter int BLINK_HALF_CYCLES  = 25000000
) (
    input  wire logic           clk,
    input  wire logic           rst,
    pcileech_board_ctl_if.slave bus
);

    localparam int c_DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_HOLD_W  = $clog2(LONGPRESS_CYCLES + 1);
    localparam int c_RST_W   = $clog2(RST_PULSE_CYCLES + 1);
    localparam int c_ACT_W   = (ACT_STRETCH_CYCLES < 1) ? 1 : $clog2(ACT_STRETCH_CYCLES + 1);
    localparam int c_BLINK_W = (BLINK_HALF_CYCLES < 2) ? 1 : $clog2(BLINK_HALF_CYCLES);

    localparam logic [c_DEB_W-1:0]   c_DEB_LAST   = c_DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0]  c_HOLD_LAST  = c_HOLD_W'(LONGPRESS_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0]  c_HOLD_MAX   = c_HOLD_W'(LONGPRESS_CYCLES);
    localparam logic [c_ACT_W-1:0]   c_ACT_LOAD   = c_ACT_W'(ACT_STRETCH_CYCLES);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_HALF_CYCLES - 1);

    // Pad level that corresponds to "not pressed"
    localparam logic [NUM_BTN-1:0] c_BTN_IDLE = (BTN_ACTIVE_LOW != 0) ? '1 : '0;

    // ------------------------------------------------------------------
    // Button path
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0]  r_sync1;
    logic [NUM_BTN-1:0]  r_sync2;
    logic [NUM_BTN-1:0]  w_pressed;
    logic [NUM_BTN-1:0]  r_level;
    logic [NUM_BTN-1:0]  r_press;
    logic [NUM_BTN-1:0]  r_release;
    logic [NUM_BTN-1:0]  r_long;
    logic [c_DEB_W-1:0]  r_deb_cnt [NUM_BTN];
    logic [c_HOLD_W-1:0] r_hold_cnt [NUM_BTN];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= c_BTN_IDLE;
            r_sync2 <= c_BTN_IDLE;
        end else begin
            r_sync1 <= bus.btn_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed = (BTN_ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

    // Debounce: the synced level must differ from the accepted level for
    // DEBOUNCE_CYCLES consecutive cycles before it is taken over. The
    // press/release events are produced in the same edge as the level flip.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            r_press   <= '0;
            r_release <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (w_pressed[i] == r_level[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == c_DEB_LAST) begin
                    r_deb_cnt[i] <= '0;
                    r_level[i]   <= w_pressed[i];
                    r_press[i]   <= w_pressed[i];
                    r_release[i] <= ~w_pressed[i];
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + c_DEB_W'(1);
                end
            end
        end
    end

    // Hold counter saturates at LONGPRESS_CYCLES so the long event fires
    // exactly once per press, LONGPRESS_CYCLES cycles after the level rose.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_long <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                r_hold_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (!r_level[i]) begin
                    r_hold_cnt[i] <= '0;
                end else if (r_hold_cnt[i] != c_HOLD_MAX) begin
                    r_hold_cnt[i] <= r_hold_cnt[i] + c_HOLD_W'(1);
                end
                r_long[i] <= r_level[i] && (r_hold_cnt[i] == c_HOLD_LAST);
            end
        end
    end

    // ------------------------------------------------------------------
    // Reset request
    // ------------------------------------------------------------------
    logic w_rst_active;

    generate
        if (RST_BTN_IDX < NUM_BTN) begin : g_rst
            logic [c_RST_W-1:0] r_rst_cnt;

            // A trigger arriving while the pulse is running is dropped, so
            // the pulse length never exceeds RST_PULSE_CYCLES.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rst_cnt <= '0;
                end else if (r_rst_cnt != '0) begin
                    r_rst_cnt <= r_rst_cnt - c_RST_W'(1);
                end else if (r_long[RST_BTN_IDX]) begin
                    r_rst_cnt <= c_RST_W'(RST_PULSE_CYCLES);
                end
            end

            assign w_rst_active = (r_rst_cnt != '0);
        end else begin : g_no_rst
            assign w_rst_active = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // LED path
    // ------------------------------------------------------------------
    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic                 r_blink_phase;
    logic [c_ACT_W-1:0]   r_act_cnt [NUM_LED];
    logic [NUM_LED-1:0]   w_act_on;
    logic [NUM_LED-1:0]   w_mode_val;
    logic [NUM_LED-1:0]   r_led;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_blink_cnt == c_BLINK_LAST) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + c_BLINK_W'(1);
        end
    end

    // A new strobe reloads the stretch even if a decrement was due.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LED; i++) begin
                r_act_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LED; i++) begin
                if (bus.led_act[i]) begin
                    r_act_cnt[i] <= c_ACT_LOAD;
                end else if (r_act_cnt[i] != '0) begin
                    r_act_cnt[i] <= r_act_cnt[i] - c_ACT_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_act_on   = '0;
        w_mode_val = '0;
        for (int i = 0; i < NUM_LED; i++) begin
            w_act_on[i] = bus.led_act[i] | (r_act_cnt[i] != '0);
            case (bus.led_mode[2*i +: 2])
                2'b00:   w_mode_val[i] = 1'b0;
                2'b01:   w_mode_val[i] = 1'b1;
                2'b10:   w_mode_val[i] = w_act_on[i];
                default: w_mode_val[i] = r_blink_phase;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led <= '0;
        end else begin
            r_led <= w_mode_val ^ bus.led_invert;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.btn_level   = r_level;
    assign bus.btn_press   = r_press;
    assign bus.btn_release = r_release;
    assign bus.btn_long    = r_long;
    assign bus.rst_req     = w_rst_active;
    assign bus.led_out     = r_led;

endmodule
`default_nettype wire

// File: tb/tb_pcileech_board_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcileech_board_ctl
// Description : Self-checking bench for pcileech_board_ctl with short timing
//               parameters (debounce 4, long press 20, reset pulse 3,
//               activity stretch 5, blink half-period 8), active-low buttons.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcileech_board_ctl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pcileech_board_ctl_if #(.NUM_BTN(2), .NUM_LED(2)) bus ();

    pcileech_board_ctl #(
        .NUM_BTN           (2),
        .NUM_LED           (2),
        .BTN_ACTIVE_LOW    (1),
        .DEBOUNCE_CYCLES   (4),
        .LONGPRESS_CYCLES  (20),
        .RST_BTN_IDX       (1),
        .RST_PULSE_CYCLES  (3),
        .ACT_STRETCH_CYCLES(5),
        .BLINK_HALF_CYCLES (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Event recorder filled by watch()
    int ev_press_cnt [2];
    int ev_press_at  [2];
    int ev_rel_cnt   [2];
    int ev_rel_at    [2];
    int ev_long_cnt  [2];
    int ev_long_at   [2];
    int rst_hi;
    int rst_first;

    typedef struct {
        logic [3:0] mode;
        logic [1:0] inv;
        logic [1:0] act;
        logic [1:0] exp_out;
    } led_vec_t;

    led_vec_t vecs [10];

    task automatic check(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run n cycles recording all events; after cycle rel_at the buttons in
    // rel_mask are returned to the released (high) pad level.
    task automatic watch(input int n, input int rel_at, input logic [1:0] rel_mask);
        for (int c = 0; c < 2; c++) begin
            ev_press_cnt[c] = 0; ev_press_at[c] = -1;
            ev_rel_cnt[c]   = 0; ev_rel_at[c]   = -1;
            ev_long_cnt[c]  = 0; ev_long_at[c]  = -1;
        end
        rst_hi    = 0;
        rst_first = -1;
        for (int i = 1; i <= n; i++) begin
            tick();
            for (int c = 0; c < 2; c++) begin
                if (bus.btn_press[c]) begin
                    if (ev_press_cnt[c] == 0) ev_press_at[c] = i;
                    ev_press_cnt[c]++;
                end
                if (bus.btn_release[c]) begin
                    if (ev_rel_cnt[c] == 0) ev_rel_at[c] = i;
                    ev_rel_cnt[c]++;
                end
                if (bus.btn_long[c]) begin
                    if (ev_long_cnt[c] == 0) ev_long_at[c] = i;
                    ev_long_cnt[c]++;
                end
            end
            if (bus.rst_req) begin
                if (rst_hi == 0) rst_first = i;
                rst_hi++;
            end
            if (i == rel_at) bus.btn_in = bus.btn_in | rel_mask;
        end
    endtask

    function automatic int all_outs();
        return int'({bus.btn_level, bus.btn_press, bus.btn_release,
                     bus.btn_long, bus.rst_req, bus.led_out});
    endfunction

    initial begin
        bit found;
        logic prev;

        vecs[0] = '{4'b0000, 2'b00, 2'b00, 2'b00};
        vecs[1] = '{4'b0101, 2'b00, 2'b00, 2'b11};
        vecs[2] = '{4'b0101, 2'b01, 2'b00, 2'b10};
        vecs[3] = '{4'b0001, 2'b10, 2'b00, 2'b11};
        vecs[4] = '{4'b1010, 2'b00, 2'b00, 2'b00};
        vecs[5] = '{4'b1010, 2'b10, 2'b00, 2'b10};
        vecs[6] = '{4'b1010, 2'b00, 2'b01, 2'b01};
        vecs[7] = '{4'b0110, 2'b00, 2'b00, 2'b11};
        vecs[8] = '{4'b0000, 2'b11, 2'b00, 2'b11};
        vecs[9] = '{4'b0100, 2'b11, 2'b10, 2'b01};

        // ---- reset with button 0 held -------------------------------
        bus.btn_in     = 2'b10;
        bus.led_mode   = 4'b0101;
        bus.led_act    = 2'b00;
        bus.led_invert = 2'b00;
        rst            = 1'b1;
        tick(); tick(); tick();
        check("reset_outputs", all_outs(), 0);
        bus.led_mode = 4'b0000;
        rst = 1'b0;
        watch(8, 0, 2'b00);
        check("held_press_latency", ev_press_at[0], 6);
        check("held_press_count", ev_press_cnt[0], 1);
        check("held_level", int'(bus.btn_level[0]), 1);

        bus.btn_in = 2'b11;
        watch(10, 0, 2'b00);
        check("held_release_latency", ev_rel_at[0], 6);

        // ---- LED mode / invert table ---------------------------------
        for (int v = 0; v < 10; v++) begin
            bus.led_mode   = vecs[v].mode;
            bus.led_invert = vecs[v].inv;
            bus.led_act    = vecs[v].act;
            tick();
            bus.led_act = 2'b00;
            check($sformatf("led_vec%0d", v), int'(bus.led_out), int'(vecs[v].exp_out));
        end
        bus.led_mode   = 4'b0000;
        bus.led_invert = 2'b00;

        // ---- glitch rejection ----------------------------------------
        bus.btn_in = 2'b10;
        watch(15, 3, 2'b01);
        check("glitch_press", ev_press_cnt[0], 0);
        check("glitch_release", ev_rel_cnt[0], 0);
        check("glitch_level", int'(bus.btn_level[0]), 0);

        // ---- 10-cycle press ------------------------------------------
        bus.btn_in = 2'b10;
        watch(24, 10, 2'b01);
        check("short_press_count", ev_press_cnt[0], 1);
        check("short_press_at", ev_press_at[0], 6);
        check("short_release_count", ev_rel_cnt[0], 1);
        check("short_release_at", ev_rel_at[0], 16);
        check("short_no_long", ev_long_cnt[0], 0);

        // ---- long press on the reset button --------------------------
        bus.btn_in = 2'b01;
        watch(45, 30, 2'b10);
        check("long1_press_at", ev_press_at[1], 6);
        check("long1_count", ev_long_cnt[1], 1);
        check("long1_at", ev_long_at[1], 26);
        check("long1_rst_first", rst_first, 27);
        check("long1_rst_len", rst_hi, 3);
        check("long1_release_at", ev_rel_at[1], 36);

        // ---- long press on the other button --------------------------
        bus.btn_in = 2'b10;
        watch(45, 30, 2'b01);
        check("long0_count", ev_long_cnt[0], 1);
        check("long0_at", ev_long_at[0], 26);
        check("long0_no_rst", rst_hi, 0);

        // ---- activity stretch ----------------------------------------
        bus.led_mode = 4'b1010;
        for (int i = 0; i < 10; i++) tick();
        for (int i = 0; i < 8; i++) begin
            if (i == 0) bus.led_act = 2'b01;
            tick();
            bus.led_act = 2'b00;
            check($sformatf("act1_t%0d", i), int'(bus.led_out[0]), (i <= 5) ? 1 : 0);
        end
        check("act1_other_led", int'(bus.led_out[1]), 0);
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 12; i++) begin
            if (i == 0 || i == 3) bus.led_act = 2'b01;
            tick();
            bus.led_act = 2'b00;
            check($sformatf("act2_t%0d", i), int'(bus.led_out[0]), (i <= 8) ? 1 : 0);
        end

        // ---- blink / invert ------------------------------------------
        bus.led_mode = 4'b1111;
        tick();
        found = 1'b0;
        prev  = bus.led_out[0];
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.led_out[0] && !prev) begin
                found = 1'b1;
                break;
            end
            prev = bus.led_out[0];
        end
        check("blink_rise_found", int'(found), 1);
        for (int i = 1; i < 32; i++) begin
            tick();
            check($sformatf("blink_t%0d", i), int'(bus.led_out[0]), ((i % 16) < 8) ? 1 : 0);
        end
        bus.led_invert = 2'b01;
        tick();
        check("blink_inv_led0", int'(bus.led_out[0]), 0);
        check("blink_inv_led1", int'(bus.led_out[1]), 1);
        for (int i = 33; i <= 40; i++) begin
            tick();
            check($sformatf("blink_inv_t%0d", i), int'(bus.led_out[0]), ((i % 16) < 8) ? 0 : 1);
        end
        bus.led_mode = 4'b0101;
        tick();
        check("on_inverted", int'(bus.led_out), 2);
        bus.led_invert = 2'b00;

        // ---- reset mid-operation -------------------------------------
        bus.btn_in = 2'b01;
        for (int i = 0; i < 25; i++) tick();
        bus.btn_in = 2'b00;
        tick(); tick();
        check("mid_rst_req_high", int'(bus.rst_req), 1);
        check("mid_led_on", int'(bus.led_out), 3);
        #2;
        rst = 1'b1;
        #1;
        check("mid_reset_outputs", all_outs(), 0);
        bus.btn_in = 2'b11;
        tick(); tick(); tick();
        check("mid_reset_held", all_outs(), 0);
        rst = 1'b0;
        watch(40, 0, 2'b00);
        check("post_rst_press", ev_press_cnt[0] + ev_press_cnt[1], 0);
        check("post_rst_release", ev_rel_cnt[0] + ev_rel_cnt[1], 0);
        check("post_rst_long", ev_long_cnt[0] + ev_long_cnt[1], 0);
        check("post_rst_req", rst_hi, 0);
        check("post_rst_level", int'(bus.btn_level), 0);
        check("post_rst_led", int'(bus.led_out), 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pcileech_board_ctl.md
Name: pcileech_board_ctl

Overview:
Parametrised board-level user-I/O controller for PCILeech FPGA top modules. It replaces the ad-hoc direct wiring of raw buttons and LEDs with N synchronised, debounced button channels, each with press/release/long-press events. It generates a stretched reset request from a designated button's long press. It drives M LEDs with selectable per-LED modes (off, on, activity-stretch, blink) and per-LED inversion. It sits in each board top between the pads and pcileech_com, pcileech_fifo and the PCIe cores.

Parameters:
NUM_BTN, 2, number of button channels (1..8)
NUM_LED, 2, number of LED channels (1..8)
BTN_ACTIVE_LOW, 1, 1 = pressed pad reads 0
DEBOUNCE_CYCLES, 1000000, cycles of stable synced input required before accepting a change (>=2)
LONGPRESS_CYCLES, 200000000, cycles held before the long-press event (> DEBOUNCE_CYCLES)
RST_BTN_IDX, 1, button index whose long press raises rst_req; value >= NUM_BTN disables the function
RST_PULSE_CYCLES, 16, rst_req high duration (>=1)
ACT_STRETCH_CYCLES, 5000000, LED activity hold time after the last led_act pulse
BLINK_HALF_CYCLES, 25000000, blink half-period

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous active-high reset
btn_in  in  NUM_BTN  raw button pads, asynchronous
btn_level  out  NUM_BTN  debounced pressed state, 1 = pressed
btn_press  out  NUM_BTN  1-cycle pulse on debounced press
btn_release  out  NUM_BTN  1-cycle pulse on debounced release
btn_long  out  NUM_BTN  1-cycle pulse when a hold reaches LONGPRESS_CYCLES
rst_req  out  1  reset request, high for RST_PULSE_CYCLES
led_mode  in  2*NUM_LED  per-LED mode; bits [2i+1:2i]: 00 off, 01 on, 10 activity, 11 blink
led_act  in  NUM_LED  activity strobes, synchronous to clk
led_invert  in  NUM_LED  per-LED output inversion
led_out  out  NUM_LED  LED drive

Behaviour:
- Reset is asynchronous active-high. On reset, all outputs are 0, all counters are 0, synchroniser flops and the debounced state take the released level, the blink phase is 0, and the stretch counters are 0.
- Input conditioning: 2-flop synchroniser per button, then polarity normalisation (pressed = 1).
- Debounce, per channel:
  - Counter deb_cnt, width $clog2(DEBOUNCE_CYCLES+1).
  - While synced != btn_level: deb_cnt increments.
  - When synced == btn_level: deb_cnt clears.
  - When deb_cnt == DEBOUNCE_CYCLES-1 and synced still differs: btn_level toggles next cycle and deb_cnt clears.
  - A glitch shorter than DEBOUNCE_CYCLES produces no event.
- Events:
  - btn_press / btn_release are registered and assert in the same cycle btn_level changes.
  - Press-to-btn_level latency is 2 (sync) + DEBOUNCE_CYCLES cycles.
- Long press, per channel:
  - Counter hold_cnt increments while btn_level = 1 and saturates at LONGPRESS_CYCLES.
  - btn_long pulses once in the cycle hold_cnt reaches LONGPRESS_CYCLES-1, i.e. LONGPRESS_CYCLES cycles after btn_level rose.
  - hold_cnt clears on release; a new press is required for another btn_long.
- Reset request:
  - btn_long[RST_BTN_IDX] loads rst_cnt = RST_PULSE_CYCLES.
  - rst_req = (rst_cnt != 0), and rst_cnt decrements to 0.
  - A trigger while rst_req is high is ignored, i.e. no extension.
- Blink: one shared blink_cnt counts 0..BLINK_HALF_CYCLES-1 and wraps; blink_phase toggles on each wrap.
- Activity stretch, per LED:
  - led_act = 1 loads act_cnt = ACT_STRETCH_CYCLES; otherwise act_cnt decrements to 0.
  - act_on = led_act | (act_cnt != 0).
  - Simultaneous load and decrement: load wins.
- LED output:
  - led_out[i] is registered, equal to mode_value XOR led_invert[i].
  - mode_value: 00 → 0, 01 → 1, 10 → act_on, 11 → blink_phase.
  - Latency is 1 cycle from input to led_out.
  - Mode changes take effect on the next cycle; counters are not cleared by mode changes.
- Reset mid-operation clears everything immediately, including an active rst_req and in-progress debounce.
- After reset release with a button physically held, the press is detected normally after the debounce time.

Test Plan (DEBOUNCE_CYCLES=4, LONGPRESS_CYCLES=20, RST_PULSE_CYCLES=3, ACT_STRETCH_CYCLES=5, BLINK_HALF_CYCLES=8):
- Reset: assert rst with btn_in held pressed → all outputs 0. Release rst → btn_level[0]=1 and btn_press[0] pulses exactly 6 cycles later.
- Glitch rejection: press btn_in[0] for 3 cycles, then release → no btn_press and btn_level stays 0. A 10-cycle press → one btn_press, then one btn_release 6 cycles after the pad releases.
- Long press / reset: hold btn[1] for 30 cycles → btn_long[1] pulses 20 cycles after btn_level[1] rose, and rst_req is high for exactly 3 cycles. Hold btn[0] for 30 cycles → btn_long[0] pulses and rst_req stays 0.
- Activity mode: led_mode=10 with a single led_act pulse at cycle T → led_out high from T+1 through T+6. A second pulse at T+3 extends it through T+9.
- Blink/invert: led_mode=11 → led_out period 16 cycles, 50% duty. Set led_invert=1 → waveform complements 1 cycle later. Mode 01 with invert=1 → led_out=0.
- Mid-operation reset: assert rst during an active rst_req and a debounce in progress → rst_req and all counters 0 immediately, and no stale events after release.
